// File: rtl/priority_codec_pkg.sv
// rtl/priority_codec_pkg.sv - shared types and decode helper for the priority encoder/decoder pair
package priority_codec_pkg;

    localparam int IDX_W_DEF  = 2;
    localparam int CNT_W_DEF  = 16;

    // Widest index the decode helper supports; callers narrow the result with a cast.
    localparam int IDX_W_MAX  = 8;
    localparam int ONEHOT_MAX = 1 << IDX_W_MAX;

    typedef struct packed {
        logic                 none;
        logic [IDX_W_DEF-1:0] idx;
    } enc_word_t;

    // One-hot of idx, or all zeros when the encoder reported no input asserted.
    function automatic logic [ONEHOT_MAX-1:0] decode_onehot(
        input logic                 none,
        input logic [IDX_W_MAX-1:0] idx
    );
        logic [ONEHOT_MAX-1:0] one;
        one = {{(ONEHOT_MAX-1){1'b0}}, 1'b1};
        if (none) begin
            return '0;
        end
        return one << idx;
    endfunction

endpackage

// File: rtl/codec_skid_buf.sv
// rtl/codec_skid_buf.sv - registered valid/ready stage with one skid entry, strictly FIFO
module codec_skid_buf #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] r_main_data;
    logic         r_main_valid;
    logic [W-1:0] r_skid_data;
    logic         r_skid_valid;

    logic w_accept;
    logic w_deliver;

    // in_ready comes straight from the skid flag, so it is a register output.
    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

    assign w_accept  = in_valid && ~r_skid_valid;
    assign w_deliver = r_main_valid && out_ready;

    // Main/skid update: skid drains into main first, new words bypass skid when main frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            if (w_deliver) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid || out_ready) begin
                r_main_data  <= in_data;
                r_main_valid <= 1'b1;
            end else begin
                r_skid_data  <= in_data;
                r_skid_valid <= 1'b1;
            end
        end else if (w_deliver) begin
            r_main_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/priority_decoder_stream.sv
// rtl/priority_decoder_stream.sv - streaming index-to-one-hot decoder with saturating delivery counters
module priority_decoder_stream
    import priority_codec_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IDX_W-1:0]        in_idx,
    input  logic                    in_none,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [(1<<IDX_W)-1:0]   out_onehot,
    input  logic                    clr_cnt,
    output logic [CNT_W-1:0]        dec_cnt,
    output logic [CNT_W-1:0]        none_cnt
);

    localparam int OUT_W = 1 << IDX_W;

    logic [OUT_W-1:0] w_onehot;
    logic [OUT_W:0]   w_in_payload;
    logic [OUT_W:0]   w_out_payload;
    logic             w_out_none;
    logic             w_deliver;

    logic [CNT_W-1:0] r_dec_cnt;
    logic [CNT_W-1:0] r_none_cnt;

    assign w_onehot     = OUT_W'(decode_onehot(in_none, IDX_W_MAX'(in_idx)));
    assign w_in_payload = {in_none, w_onehot};

    codec_skid_buf #(
        .W(OUT_W + 1)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (w_in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_out_payload)
    );

    assign out_onehot = w_out_payload[OUT_W-1:0];
    assign w_out_none = w_out_payload[OUT_W];
    assign w_deliver  = out_valid && out_ready;

    // Delivery statistics: count on handshake out, hold at all-ones, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_cnt  <= '0;
            r_none_cnt <= '0;
        end else if (clr_cnt) begin
            r_dec_cnt  <= '0;
            r_none_cnt <= '0;
        end else if (w_deliver) begin
            if (!w_out_none && !(&r_dec_cnt)) begin
                r_dec_cnt <= r_dec_cnt + 1'b1;
            end
            if (w_out_none && !(&r_none_cnt)) begin
                r_none_cnt <= r_none_cnt + 1'b1;
            end
        end
    end

    assign dec_cnt  = r_dec_cnt;
    assign none_cnt = r_none_cnt;

endmodule

// File: tb/tb_priority_decoder_stream.sv
// tb/tb_priority_decoder_stream.sv - directed self-checking bench for priority_decoder_stream
module tb_priority_decoder_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_idx;
    logic       in_none;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_onehot;
    logic       clr_cnt;
    logic [3:0] dec_cnt;
    logic [3:0] none_cnt;

    int checks;
    int failures;

    priority_decoder_stream #(
        .IDX_W(2),
        .CNT_W(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_none   (in_none),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_onehot(out_onehot),
        .clr_cnt   (clr_cnt),
        .dec_cnt   (dec_cnt),
        .none_cnt  (none_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_idx = 2'd0; in_none = 1'b0;
        out_ready = 1'b0; clr_cnt = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_onehot !== 4'b0000) begin failures++; $display("FAIL reset_onehot got=%b exp=0000", out_onehot); end
        checks++; if (dec_cnt !== 4'd0) begin failures++; $display("FAIL reset_dec_cnt got=%0d exp=0", dec_cnt); end
        checks++; if (none_cnt !== 4'd0) begin failures++; $display("FAIL reset_none_cnt got=%0d exp=0", none_cnt); end
    endtask

    task automatic test_stream();
        logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_idx = 2'(i); in_none = 1'b0;
            step();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_onehot !== exp_oh[i]) begin failures++; $display("FAIL stream_onehot[%0d] got=%b exp=%b", i, out_onehot, exp_oh[i]); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain_valid got=%b exp=0", out_valid); end
        checks++; if (dec_cnt !== 4'd4) begin failures++; $display("FAIL stream_dec_cnt got=%0d exp=4", dec_cnt); end
    endtask

    task automatic test_none();
        in_valid = 1'b1; in_idx = 2'b11; in_none = 1'b1;
        step();
        checks++; if (out_onehot !== 4'b0000) begin failures++; $display("FAIL none_onehot got=%b exp=0000", out_onehot); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL none_valid got=%b exp=1", out_valid); end
        in_valid = 1'b0; in_none = 1'b0;
        step();
        checks++; if (none_cnt !== 4'd1) begin failures++; $display("FAIL none_cnt got=%0d exp=1", none_cnt); end
        checks++; if (dec_cnt !== 4'd4) begin failures++; $display("FAIL none_dec_cnt got=%0d exp=4", dec_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_idx = 2'd1;
        step();
        checks++; if (out_onehot !== 4'b0010) begin failures++; $display("FAIL bp_first got=%b exp=0010", out_onehot); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
        in_idx = 2'd2;
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%b exp=0", in_ready); end
        checks++; if (out_onehot !== 4'b0010) begin failures++; $display("FAIL bp_hold1 got=%b exp=0010", out_onehot); end
        in_idx = 2'd3;
        step();
        checks++; if (out_onehot !== 4'b0010 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold2 got=%b/%b exp=0010/1", out_onehot, out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready3 got=%b exp=0", in_ready); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (out_onehot !== 4'b0100 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_second got=%b/%b exp=0100/1", out_onehot, out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready4 got=%b exp=1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
        checks++; if (dec_cnt !== 4'd6) begin failures++; $display("FAIL bp_dec_cnt got=%0d exp=6", dec_cnt); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_idx = 2'(i); in_none = 1'b0;
            step();
        end
        in_valid = 1'b0;
        step();
        checks++; if (dec_cnt !== 4'd15) begin failures++; $display("FAIL sat_dec_cnt got=%0d exp=15", dec_cnt); end
        checks++; if (none_cnt !== 4'd1) begin failures++; $display("FAIL sat_none_cnt got=%0d exp=1", none_cnt); end
        in_valid = 1'b1; in_idx = 2'd0;
        step();
        in_valid = 1'b0; clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        checks++; if (dec_cnt !== 4'd0) begin failures++; $display("FAIL clr_dec_cnt got=%0d exp=0", dec_cnt); end
        checks++; if (none_cnt !== 4'd0) begin failures++; $display("FAIL clr_none_cnt got=%0d exp=0", none_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_deliver got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1; in_idx = 2'd3; in_none = 1'b0;
        step();
        in_idx = 2'd0;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_skid_full got=%b exp=0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_async_ready got=%b exp=1", in_ready); end
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale[%0d] got=%b exp=0", i, out_valid); end
        end
        checks++; if (dec_cnt !== 4'd0) begin failures++; $display("FAIL mid_dec_cnt got=%0d exp=0", dec_cnt); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_none();
        test_backpressure();
        test_saturation();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
